// File: rtl/mul_call_pkg.sv
// rtl/mul_call_pkg.sv - shared types and constants for the shift-add multiplier call unit
package mul_call_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEF_WIDTH = 32;

  // Counter must be able to hold WIDTH itself, not just WIDTH-1
  function automatic int cnt_width(input int w);
    return $clog2(w) + 1;
  endfunction

  localparam int CNT_W = cnt_width(DEF_WIDTH);

endpackage

// File: rtl/mul_call_datapath.sv
// rtl/mul_call_datapath.sv - shift-add registers with load/step controls and last-iteration flag
module mul_call_datapath
  import mul_call_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             step,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] acc,
  output logic             last
);

  localparam int CW = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH);

  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic [CW-1:0]    cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      a_reg <= '0;
      b_reg <= '0;
      acc   <= '0;
      cnt   <= '0;
    end else if (load) begin
      a_reg <= a;
      b_reg <= b;
      acc   <= '0;
      cnt   <= '0;
    end else if (step) begin
      if (b_reg[0]) begin
        acc <= acc + a_reg;
      end
      a_reg <= a_reg << 1;
      b_reg <= b_reg >> 1;
      cnt   <= cnt + 1'b1;
    end
  end

  // High once all WIDTH iterations have been applied to acc
  assign last = (cnt == LAST_CNT);

endmodule

// File: rtl/mul_call_unit.sv
// rtl/mul_call_unit.sv - start/done handshake multiplier: result = a*b mod 2^WIDTH
module mul_call_unit
  import mul_call_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result,
  output logic             done
);

  state_t           state;
  logic             load;
  logic             step;
  logic             last;
  logic [WIDTH-1:0] acc;

  // start is only honoured outside CALC; an in-flight call keeps its operands
  assign load = start && (state != CALC);
  assign step = (state == CALC) && !last;

  mul_call_datapath #(
    .WIDTH(WIDTH)
  ) u_datapath (
    .clk  (clk),
    .reset(reset),
    .load (load),
    .step (step),
    .a    (a),
    .b    (b),
    .acc  (acc),
    .last (last)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      done   <= 1'b0;
      result <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            done  <= 1'b0;
            state <= CALC;
          end
        end
        CALC: begin
          if (last) begin
            result <= acc;
            done   <= 1'b1;
            state  <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mul_call_unit.sv
// tb/tb_mul_call_unit.sv - self-checking bench for mul_call_unit against a product model
module tb_mul_call_unit;

  localparam int WIDTH   = 32;
  localparam int LATENCY = WIDTH + 1;

  logic             clk;
  logic             reset;
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] result;
  logic             done;

  int checks;
  int errors;

  mul_call_unit #(
    .WIDTH(WIDTH)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .a     (a),
    .b     (b),
    .result(result),
    .done  (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [WIDTH-1:0] model(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
    logic [2*WIDTH-1:0] p;
    p = {{WIDTH{1'b0}}, x} * {{WIDTH{1'b0}}, y};
    return p[WIDTH-1:0];
  endfunction

  // Drives one start pulse; returns 1ns after the accepting edge
  task automatic accept(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
    a     = x;
    b     = y;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    a     = $urandom;
    b     = $urandom;
  endtask

  task automatic wait_done(input int from, output int lat);
    lat = from;
    while (done !== 1'b1 && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic test_reset;
    reset = 1'b0;
    start = 1'b0;
    a     = '0;
    b     = '0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    for (int i = 0; i < 50; i++) begin
      checks++;
      if (done !== 1'b0 || result !== '0) begin
        errors++;
        $display("FAIL reset_idle cycle %0d: done=%b result=%h, want done=0 result=0", i, done, result);
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_basic;
    int lat;
    accept(32'd1, 32'd2);
    wait_done(0, lat);
    checks++;
    if (lat != LATENCY) begin
      errors++;
      $display("FAIL basic_latency: got %0d, want %0d", lat, LATENCY);
    end
    checks++;
    if (result !== 32'd2) begin
      errors++;
      $display("FAIL basic_result: got %h, want %h", result, 32'd2);
    end
    repeat (5) @(posedge clk);
    #1;
    checks++;
    if (done !== 1'b1 || result !== 32'd2) begin
      errors++;
      $display("FAIL basic_hold: done=%b result=%h, want done=1 result=2", done, result);
    end
  endtask

  task automatic test_back_to_back;
    int lat;
    repeat (3) @(posedge clk);
    #1;
    accept(32'd7, 32'd4);
    checks++;
    if (done !== 1'b0 || result !== 32'd2) begin
      errors++;
      $display("FAIL b2b_accept: done=%b result=%h, want done=0 result=2", done, result);
    end
    wait_done(0, lat);
    checks++;
    if (lat != LATENCY || result !== 32'd28) begin
      errors++;
      $display("FAIL b2b_result: lat=%0d result=%h, want lat=%0d result=%h", lat, result, LATENCY, 32'd28);
    end
  endtask

  task automatic test_extremes;
    logic [WIDTH-1:0] xs [3];
    logic [WIDTH-1:0] ys [3];
    logic [WIDTH-1:0] want [3];
    int lat;
    xs[0] = 32'hFFFF_FFFF; ys[0] = 32'hFFFF_FFFF; want[0] = 32'h0000_0001;
    xs[1] = 32'h0001_0000; ys[1] = 32'h0001_0000; want[1] = 32'h0000_0000;
    xs[2] = 32'h0000_0000; ys[2] = 32'd12345;     want[2] = 32'h0000_0000;
    for (int i = 0; i < 3; i++) begin
      accept(xs[i], ys[i]);
      wait_done(0, lat);
      checks++;
      if (lat != LATENCY || result !== want[i]) begin
        errors++;
        $display("FAIL extreme_%0d: lat=%0d result=%h, want lat=%0d result=%h", i, lat, result, LATENCY, want[i]);
      end
    end
  endtask

  task automatic test_ignore_start;
    int lat;
    accept(32'd3, 32'd5);
    repeat (9) @(posedge clk);
    #1;
    a     = 32'd9;
    b     = 32'd9;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done(10, lat);
    checks++;
    if (lat != LATENCY || result !== 32'd15) begin
      errors++;
      $display("FAIL ignore_result: lat=%0d result=%h, want lat=%0d result=%h", lat, result, LATENCY, 32'd15);
    end
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      checks++;
      if (done !== 1'b1 || result !== 32'd15) begin
        errors++;
        $display("FAIL ignore_no_relaunch cycle %0d: done=%b result=%h, want done=1 result=f", i, done, result);
      end
    end
  endtask

  task automatic test_reset_mid;
    int lat;
    accept(32'd6, 32'd7);
    repeat (10) @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    checks++;
    if (done !== 1'b0 || result !== '0) begin
      errors++;
      $display("FAIL reset_mid_async: done=%b result=%h, want done=0 result=0", done, result);
    end
    @(posedge clk);
    #1;
    reset = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    checks++;
    if (done !== 1'b0 || result !== '0) begin
      errors++;
      $display("FAIL reset_mid_idle: done=%b result=%h, want done=0 result=0", done, result);
    end
    accept(32'd6, 32'd7);
    wait_done(0, lat);
    checks++;
    if (lat != LATENCY || result !== 32'd42) begin
      errors++;
      $display("FAIL reset_mid_restart: lat=%0d result=%h, want lat=%0d result=%h", lat, result, LATENCY, 32'd42);
    end
  endtask

  // Random operands; start is sometimes held for extra cycles with changing a/b
  task automatic test_random;
    logic [WIDTH-1:0] x;
    logic [WIDTH-1:0] y;
    logic [WIDTH-1:0] want;
    int hold;
    int lat;
    for (int n = 0; n < 12; n++) begin
      x    = $urandom;
      y    = (n % 3 == 0) ? WIDTH'($urandom_range(0, 255)) : WIDTH'($urandom);
      want = model(x, y);
      hold = $urandom_range(1, 3);
      a     = x;
      b     = y;
      start = 1'b1;
      @(posedge clk);
      #1;
      for (int h = 1; h < hold; h++) begin
        a = $urandom;
        b = $urandom;
        @(posedge clk);
        #1;
      end
      start = 1'b0;
      wait_done(hold - 1, lat);
      checks++;
      if (lat != LATENCY || result !== want) begin
        errors++;
        $display("FAIL random_%0d: a=%h b=%h lat=%0d result=%h, want lat=%0d result=%h",
                 n, x, y, lat, result, LATENCY, want);
      end
      repeat ($urandom_range(0, 4)) @(posedge clk);
      #1;
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset;
    test_basic;
    test_back_to_back;
    test_extremes;
    test_ignore_start;
    test_reset_mid;
    test_random;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
